// File: rtl/capi_put_pkg.sv
// capi_put_pkg
// Shared definitions for the put-command arbiter and its tag pool:
//   - FSM state type of the arbiter
//   - default tag width, aux/ctxt field widths
//   - upper bound on requester count and the index width that covers it
//   - rr_pick: cyclic round-robin priority encoder
package capi_put_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam int TAG_W   = 5;
  localparam int AUX_W   = 11;
  localparam int CTXT_W  = 10;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // Returns the first requesting index strictly after 'last', searching
  // cyclically over the first 'n' requesters. Callers only use the result
  // when at least one request bit is set.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   last,
    input int                 n
  );
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % n;
      if (!found && k <= n && req[idx[IDX_W-1:0]]) begin
        win   = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/capi_tag_pool.sv
// capi_tag_pool
// Pool of 2**tag_width command tags kept as an allocated-bit vector plus a
// free counter. Allocation always hands out the lowest-numbered free tag.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (all tags freed)
//   alloc        allocate alloc_tag this cycle (ignored when pool empty)
//   alloc_tag    lowest free tag (combinational from the pool state)
//   avail        at least one tag is free
//   free_v       return free_tag to the pool
//   free_tag     tag being returned
//   free_cnt     registered free-tag count
//   err          sticky: a tag was returned that was not allocated
module capi_tag_pool
  import capi_put_pkg::*;
#(
  parameter int tag_width = TAG_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc,
  output logic [tag_width-1:0] alloc_tag,
  output logic                 avail,
  input  logic                 free_v,
  input  logic [tag_width-1:0] free_tag,
  output logic [tag_width:0]   free_cnt,
  output logic                 err
);

  localparam int POOL = 1 << tag_width;

  logic [POOL-1:0] used_q;
  logic            free_ok;
  logic            do_alloc;

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    alloc_tag = '0;
    for (int i = POOL - 1; i >= 0; i--) begin
      if (!used_q[i]) alloc_tag = tag_width'(i);
    end
  end

  assign avail    = (free_cnt != '0);
  assign do_alloc = alloc && avail;
  // Only a tag that is currently allocated can be freed; since alloc_tag is
  // a currently free tag, the two never collide in the same cycle.
  assign free_ok  = free_v && used_q[free_tag];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      used_q   <= '0;
      free_cnt <= (tag_width + 1)'(POOL);
      err      <= 1'b0;
    end else begin
      if (free_ok)  used_q[free_tag]  <= 1'b0;
      if (do_alloc) used_q[alloc_tag] <= 1'b1;
      if (free_v && !free_ok) err <= 1'b1;
      free_cnt <= free_cnt - (tag_width + 1)'(do_alloc) + (tag_width + 1)'(free_ok);
    end
  end

endmodule

// File: rtl/capi_put128_arb.sv
// capi_put128_arb
// Round-robin arbiter and tag allocator sharing one put-command encoder
// between nreq write-stream requesters. A grant is held from the address
// phase until the end beat is accepted; the granted requester's fields and
// an allocated tag are presented to the encoder, all from registers.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   i_req_v[nreq]                  per-requester request (bit i = requester i)
//   i_req_ea/sid/aux/ctxt          packed per-requester fields, requester 0 in MSBs
//   i_req_f[nreq]                  per-requester f bit (bit i = requester i)
//   i_enable                       gates new grants only
//   o_gnt                          one-hot grant, held through the transfer
//   o_addr_v                       one-cycle address strobe
//   o_addr_ea/o_sid/o_f/o_aux/o_ctxt  granted requester's fields
//   o_cmd_tag                      allocated tag
//   i_data_v/i_data_r/i_data_e     muxed data handshake (end beat = all three)
//   i_rsp_v, i_rsp_tag             tag return
//   o_tags_free                    free-tag count
//   o_err                          sticky bad-tag-return flag
module capi_put128_arb
  import capi_put_pkg::*;
#(
  parameter int ea_width  = 65,
  parameter int sid_width = 3,
  parameter int nreq      = 4,
  parameter int tag_width = TAG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [nreq-1:0]             i_req_v,
  input  logic [nreq*ea_width-1:0]    i_req_ea,
  input  logic [nreq*sid_width-1:0]   i_req_sid,
  input  logic [nreq-1:0]             i_req_f,
  input  logic [nreq*AUX_W-1:0]       i_req_aux,
  input  logic [nreq*CTXT_W-1:0]      i_req_ctxt,
  input  logic                        i_enable,
  output logic [nreq-1:0]             o_gnt,
  output logic                        o_addr_v,
  output logic [ea_width-1:0]         o_addr_ea,
  output logic [tag_width-1:0]        o_cmd_tag,
  output logic [sid_width-1:0]        o_sid,
  output logic                        o_f,
  output logic [AUX_W-1:0]            o_aux,
  output logic [CTXT_W-1:0]           o_ctxt,
  input  logic                        i_data_v,
  input  logic                        i_data_r,
  input  logic                        i_data_e,
  input  logic                        i_rsp_v,
  input  logic [tag_width-1:0]        i_rsp_tag,
  output logic [tag_width:0]          o_tags_free,
  output logic                        o_err
);

  // Per-requester views, padded to MAX_REQ entries so the 3-bit winner
  // index selects directly without width adaptation.
  logic [ea_width-1:0]  req_ea   [MAX_REQ];
  logic [sid_width-1:0] req_sid  [MAX_REQ];
  logic                 req_f    [MAX_REQ];
  logic [AUX_W-1:0]     req_aux  [MAX_REQ];
  logic [CTXT_W-1:0]    req_ctxt [MAX_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
      if (gi < nreq) begin : g_live
        assign req_ea[gi]   = i_req_ea[(nreq-1-gi)*ea_width +: ea_width];
        assign req_sid[gi]  = i_req_sid[(nreq-1-gi)*sid_width +: sid_width];
        assign req_f[gi]    = i_req_f[gi];
        assign req_aux[gi]  = i_req_aux[(nreq-1-gi)*AUX_W +: AUX_W];
        assign req_ctxt[gi] = i_req_ctxt[(nreq-1-gi)*CTXT_W +: CTXT_W];
      end else begin : g_pad
        assign req_ea[gi]   = '0;
        assign req_sid[gi]  = '0;
        assign req_f[gi]    = 1'b0;
        assign req_aux[gi]  = '0;
        assign req_ctxt[gi] = '0;
      end
    end
  endgenerate

  state_t               state_q, state_next;
  logic [IDX_W-1:0]     last_q;
  logic [IDX_W-1:0]     gnt_idx_q;
  logic [IDX_W-1:0]     win_idx;
  logic [MAX_REQ-1:0]   req_ext;
  logic [nreq-1:0]      gnt_onehot;
  logic                 end_beat;
  logic                 take_grant;
  logic                 release_gnt;
  logic                 pool_avail;
  logic [tag_width-1:0] alloc_tag;

  always_comb begin
    req_ext           = '0;
    req_ext[nreq-1:0] = i_req_v;
  end

  assign win_idx  = rr_pick(req_ext, last_q, nreq);
  assign end_beat = i_data_v & i_data_r & i_data_e;

  generate
    for (gi = 0; gi < nreq; gi++) begin : g_onehot
      assign gnt_onehot[gi] = (win_idx == IDX_W'(gi));
    end
  endgenerate

  // Next-state logic. A transfer can end in ADDR when it is a single beat.
  always_comb begin
    state_next  = state_q;
    take_grant  = 1'b0;
    release_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable && (|i_req_v) && pool_avail) begin
          take_grant = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (end_beat) begin
          release_gnt = 1'b1;
          state_next  = IDLE;
        end else begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (end_beat) begin
          release_gnt = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  // Registered grant and field outputs. Fields and tag keep their values
  // after the grant drops; they only change on the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_gnt     <= '0;
      o_addr_v  <= 1'b0;
      o_addr_ea <= '0;
      o_cmd_tag <= '0;
      o_sid     <= '0;
      o_f       <= 1'b0;
      o_aux     <= '0;
      o_ctxt    <= '0;
      gnt_idx_q <= '0;
      last_q    <= IDX_W'(nreq - 1);
    end else begin
      o_addr_v <= take_grant;
      if (take_grant) begin
        o_gnt     <= gnt_onehot;
        gnt_idx_q <= win_idx;
        o_cmd_tag <= alloc_tag;
        o_addr_ea <= req_ea[win_idx];
        o_sid     <= req_sid[win_idx];
        o_f       <= req_f[win_idx];
        o_aux     <= req_aux[win_idx];
        o_ctxt    <= req_ctxt[win_idx];
      end
      if (release_gnt) begin
        o_gnt  <= '0;
        last_q <= gnt_idx_q;
      end
    end
  end

  capi_tag_pool #(
    .tag_width (tag_width)
  ) u_tag_pool (
    .clk       (clk),
    .reset     (reset),
    .alloc     (take_grant),
    .alloc_tag (alloc_tag),
    .avail     (pool_avail),
    .free_v    (i_rsp_v),
    .free_tag  (i_rsp_tag),
    .free_cnt  (o_tags_free),
    .err       (o_err)
  );

endmodule

// File: tb/tb_capi_put128_arb.sv
// tb_capi_put128_arb
// Self-checking bench for capi_put128_arb: a reset-relative vector table,
// hand sequences for the multi-cycle corner cases, and a randomized run,
// all compared every cycle against a transaction-level reference model.
module tb_capi_put128_arb;

  localparam int EA   = 65;
  localparam int SW   = 3;
  localparam int NR   = 4;
  localparam int TW   = 5;
  localparam int POOL = 1 << TW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_v = '0;
  logic [NR*EA-1:0]  req_ea = '0;
  logic [NR*SW-1:0]  req_sid = '0;
  logic [NR-1:0]     req_f = '0;
  logic [NR*11-1:0]  req_aux = '0;
  logic [NR*10-1:0]  req_ctxt = '0;
  logic              enable = 1'b1;
  logic [NR-1:0]     gnt;
  logic              addr_v;
  logic [EA-1:0]     addr_ea;
  logic [TW-1:0]     cmd_tag;
  logic [SW-1:0]     sid;
  logic              f;
  logic [10:0]       aux;
  logic [9:0]        ctxt;
  logic              data_v = 1'b0, data_r = 1'b0, data_e = 1'b0;
  logic              rsp_v = 1'b0;
  logic [TW-1:0]     rsp_tag = '0;
  logic [TW:0]       tags_free;
  logic              err;

  capi_put128_arb #(.ea_width(EA), .sid_width(SW), .nreq(NR), .tag_width(TW)) dut (
    .clk(clk), .reset(reset),
    .i_req_v(req_v), .i_req_ea(req_ea), .i_req_sid(req_sid), .i_req_f(req_f),
    .i_req_aux(req_aux), .i_req_ctxt(req_ctxt), .i_enable(enable),
    .o_gnt(gnt), .o_addr_v(addr_v), .o_addr_ea(addr_ea), .o_cmd_tag(cmd_tag),
    .o_sid(sid), .o_f(f), .o_aux(aux), .o_ctxt(ctxt),
    .i_data_v(data_v), .i_data_r(data_r), .i_data_e(data_e),
    .i_rsp_v(rsp_v), .i_rsp_tag(rsp_tag),
    .o_tags_free(tags_free), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-requester stimulus fields (requester i at index i).
  logic [EA-1:0] r_ea   [NR];
  logic [SW-1:0] r_sid  [NR];
  logic          r_f    [NR];
  logic [10:0]   r_aux  [NR];
  logic [9:0]    r_ctxt [NR];

  // Reference model state.
  int            m_owner;     // granted requester, -1 when none
  bit            m_addr_v;
  int            m_tag;
  int            m_last;
  bit            m_used [POOL];
  bit            m_err;
  logic [EA-1:0] m_ea;
  logic [SW-1:0] m_sid;
  logic          m_f;
  logic [10:0]   m_aux;
  logic [9:0]    m_ctxt;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic randomize_fields();
    logic [95:0] t;
    for (int i = 0; i < NR; i++) begin
      t = {$urandom(), $urandom(), $urandom()};
      r_ea[i]   = t[EA-1:0];
      r_sid[i]  = SW'($urandom_range(0, 7));
      r_f[i]    = 1'($urandom_range(0, 1));
      r_aux[i]  = 11'($urandom_range(0, 2047));
      r_ctxt[i] = 10'($urandom_range(0, 1023));
    end
    for (int i = 0; i < NR; i++) begin
      req_ea[(NR-1-i)*EA +: EA]   = r_ea[i];
      req_sid[(NR-1-i)*SW +: SW]  = r_sid[i];
      req_f[i]                    = r_f[i];
      req_aux[(NR-1-i)*11 +: 11]  = r_aux[i];
      req_ctxt[(NR-1-i)*10 +: 10] = r_ctxt[i];
    end
  endtask

  function automatic int m_free();
    int c = 0;
    for (int t = 0; t < POOL; t++) if (!m_used[t]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_addr_v = 1'b0;
    m_tag    = 0;
    m_last   = NR - 1;
    m_err    = 1'b0;
    m_ea = '0; m_sid = '0; m_f = 1'b0; m_aux = '0; m_ctxt = '0;
    for (int t = 0; t < POOL; t++) m_used[t] = 1'b0;
  endtask

  // One clock of arbiter behaviour at transfer level: pick a winner when
  // nobody owns the encoder, end ownership on an accepted end beat, and
  // account tags as a set of allocated numbers.
  task automatic model_step();
    int w = -1;
    int nt = -1;
    bit freeing = 1'b0;
    if (m_owner < 0 && enable && req_v != '0 && m_free() > 0) begin
      for (int k = 1; k <= NR; k++) begin
        if (w < 0 && req_v[(m_last + k) % NR]) w = (m_last + k) % NR;
      end
      for (int t = 0; t < POOL; t++) if (nt < 0 && !m_used[t]) nt = t;
    end
    if (rsp_v) begin
      if (m_used[rsp_tag]) freeing = 1'b1;
      else m_err = 1'b1;
    end
    if (freeing) m_used[rsp_tag] = 1'b0;
    m_addr_v = (w >= 0);
    if (w >= 0) begin
      m_owner = w;
      m_tag   = nt;
      m_used[nt] = 1'b1;
      m_ea = r_ea[w]; m_sid = r_sid[w]; m_f = r_f[w]; m_aux = r_aux[w]; m_ctxt = r_ctxt[w];
    end else if (m_owner >= 0 && data_v && data_r && data_e) begin
      m_last  = m_owner;
      m_owner = -1;
    end
  endtask

  task automatic check_all();
    logic [NR-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("gnt", 96'(gnt), 96'(eg));
    chk("addr_v", 96'(addr_v), 96'(m_addr_v));
    chk("tags_free", 96'(tags_free), 96'(m_free()));
    chk("err", 96'(err), 96'(m_err));
    if (m_owner >= 0) begin
      chk("cmd_tag", 96'(cmd_tag), 96'(m_tag));
      chk("addr_ea", 96'(addr_ea), 96'(m_ea));
      chk("fields", 96'({sid, f, aux, ctxt}), 96'({m_sid, m_f, m_aux, m_ctxt}));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_end(input bit e);
    data_v = e; data_r = e; data_e = e;
  endtask

  // Reset asserted between edges (asynchronously), checked one cycle later.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    chk("reset_tags_free", 96'(tags_free), 96'(POOL));
    reset = 1'b0;
  endtask

  typedef struct {
    logic [NR-1:0] req;
    bit            endb;
    logic [NR-1:0] gnt;
    bit            addr_v;
    int            tag;
    int            free;
  } vec_t;

  vec_t vt [10];

  initial begin
    int pulses;
    // Back-to-back single-beat transfers with all four requesting.
    vt[0] = '{4'hF, 1, 4'b0001, 1, 0, 31};
    vt[1] = '{4'hF, 1, 4'b0000, 0, 0, 31};
    vt[2] = '{4'hF, 1, 4'b0010, 1, 1, 30};
    vt[3] = '{4'hF, 1, 4'b0000, 0, 1, 30};
    vt[4] = '{4'hF, 1, 4'b0100, 1, 2, 29};
    vt[5] = '{4'hF, 1, 4'b0000, 0, 2, 29};
    vt[6] = '{4'hF, 1, 4'b1000, 1, 3, 28};
    vt[7] = '{4'hF, 1, 4'b0000, 0, 3, 28};
    vt[8] = '{4'hF, 1, 4'b0001, 1, 4, 27};
    vt[9] = '{4'hF, 1, 4'b0000, 0, 4, 27};

    randomize_fields();
    model_reset();
    #2;
    do_reset();
    chk("reset_gnt", 96'(gnt), 96'(0));
    chk("reset_err", 96'(err), 96'(0));

    for (int i = 0; i < 10; i++) begin
      req_v = vt[i].req;
      set_end(vt[i].endb);
      tick();
      chk($sformatf("vec%0d_gnt", i), 96'(gnt), 96'(vt[i].gnt));
      chk($sformatf("vec%0d_addr_v", i), 96'(addr_v), 96'(vt[i].addr_v));
      chk($sformatf("vec%0d_free", i), 96'(tags_free), 96'(vt[i].free));
      if (vt[i].gnt != '0) chk($sformatf("vec%0d_tag", i), 96'(cmd_tag), 96'(vt[i].tag));
    end

    // Requester 2 alone, 5-beat transfer, ready low for 3 cycles.
    do_reset();
    req_v = 4'b0100;
    set_end(1'b0);
    pulses = 0;
    tick();
    if (addr_v) pulses++;
    chk("r2_gnt_first", 96'(gnt), 96'(4'b0100));
    req_v = '0;
    for (int i = 0; i < 8; i++) begin
      data_v = 1'b1;
      data_r = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
      data_e = (i == 7);
      tick();
      if (addr_v) pulses++;
      if (i < 7) chk("r2_gnt_hold", 96'(gnt), 96'(4'b0100));
    end
    chk("r2_gnt_end", 96'(gnt), 96'(0));
    chk("r2_addr_pulses", 96'(pulses), 96'(1));
    set_end(1'b0);

    // Pool exhaustion: 32 single-beat transfers, then no further grant.
    do_reset();
    req_v = 4'hF;
    set_end(1'b1);
    for (int i = 0; i < 2 * POOL; i++) tick();
    chk("exh_free", 96'(tags_free), 96'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("exh_no_gnt", 96'(gnt), 96'(0));
    end
    rsp_v = 1'b1; rsp_tag = TW'(1);
    tick();
    rsp_v = 1'b0;
    tick();
    chk("exh_regrant_tag", 96'(cmd_tag), 96'(1));
    chk("exh_regrant_v", 96'(addr_v), 96'(1));

    // Free and alloc in the same cycle.
    do_reset();
    req_v = 4'hF;
    set_end(1'b1);
    for (int i = 0; i < 8; i++) tick();
    req_v = '0;
    rsp_v = 1'b1; rsp_tag = TW'(0);
    tick();
    chk("same_pre_free", 96'(tags_free), 96'(29));
    req_v = 4'hF;
    rsp_tag = TW'(3);
    tick();
    rsp_v = 1'b0;
    chk("same_free", 96'(tags_free), 96'(29));
    chk("same_tag0", 96'(cmd_tag), 96'(0));
    tick();
    tick();
    chk("same_next_tag3", 96'(cmd_tag), 96'(3));
    req_v = '0;
    tick();

    // Response for an unallocated tag: sticky error, pool untouched.
    rsp_v = 1'b1; rsp_tag = TW'(7);
    tick();
    rsp_v = 1'b0;
    chk("bad_err", 96'(err), 96'(1));
    chk("bad_free", 96'(tags_free), 96'(28));
    tick();
    tick();
    chk("bad_err_sticky", 96'(err), 96'(1));

    // Reset while in XFER.
    req_v = 4'b0010;
    set_end(1'b0);
    tick();
    tick();
    chk("xfer_busy", 96'(gnt), 96'(4'b0010));
    #2;
    do_reset();
    chk("rst_gnt", 96'(gnt), 96'(0));
    chk("rst_err", 96'(err), 96'(0));
    req_v = 4'hF;
    set_end(1'b1);
    tick();
    chk("rst_first_winner", 96'(gnt), 96'(4'b0001));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_v   = NR'($urandom_range(0, 15));
      enable  = ($urandom_range(0, 9) != 0);
      data_v  = ($urandom_range(0, 3) != 0);
      data_r  = ($urandom_range(0, 3) != 0);
      data_e  = ($urandom_range(0, 2) == 0);
      rsp_v   = ($urandom_range(0, 2) == 0);
      rsp_tag = TW'($urandom_range(0, 9));
      if ((c % 7) == 0) randomize_fields();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
